// File: rtl/reg_file.sv
// Register file: 2**ADDR_WIDTH entries with x0 hard-wired to zero, two combinational read
// ports with optional same-cycle write forwarding, a registered debug read port and a
// free-running count of committed writes.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [31:0]           write_count
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [DATA_WIDTH-1:0] dbg_data_q;
  logic [31:0]           write_count_q;

  logic write_en;
  logic fwd1;
  logic fwd2;

  // A write commits only outside reset and never to x0.
  assign write_en = rst_n && RegWrite && (rd != '0);

  // Forwarding is suppressed during reset so the ignored write never leaks onto the ports.
  assign fwd1 = BYPASS && write_en && (rs1 == rd);
  assign fwd2 = BYPASS && write_en && (rs2 == rd);

  // Register array: synchronous clear, then single write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_en) begin
      regs_q[rd] <= write_data;
    end
  end

  // Debug read samples pre-edge contents; write counter wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbg_data_q    <= '0;
      write_count_q <= '0;
    end else begin
      dbg_data_q <= (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
      if (write_en) begin
        write_count_q <= write_count_q + 32'd1;
      end
    end
  end

  // Read port 1: x0 reads zero, otherwise forwarded or stored value.
  always_comb begin
    read_data1 = '0;
    if (rs1 != '0) begin
      read_data1 = fwd1 ? write_data : regs_q[rs1];
    end
  end

  // Read port 2: identical structure to port 1 so equal indices give equal data.
  always_comb begin
    read_data2 = '0;
    if (rs2 != '0) begin
      read_data2 = fwd2 ? write_data : regs_q[rs2];
    end
  end

  assign dbg_data    = dbg_data_q;
  assign write_count = write_count_q;

endmodule
